// File: rtl/rf_refresh_scheduler.sv
// Refresh scheduler: epoch walker handshake, t_refi staging, owed-refresh count.
// Optional RF_SCHED_HYST_EN: stage a prediction only when it repeats.
module rf_refresh_scheduler #(
  parameter int TICK_DIV      = 16,
  parameter int EPOCH_CYCLES  = 4096,
  parameter int WALK_TIMEOUT  = 64,
  parameter int MAX_PENDING   = 8,
  parameter int DEFAULT_TREFI = 64,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       walk_start,
  input  logic       walk_done,
  input  logic [7:0] walk_t_refi,
  output logic       ref_req,
  input  logic       ref_ack,
  output logic [7:0] cur_t_refi,
  output logic [3:0] pending,
  input  logic       clr_err,
  output logic       err_timeout,
  output logic       err_invalid,
  output logic       err_overflow
`ifdef RF_SCHED_HYST_EN
  ,
  output logic       hyst_hold
`endif
);

  localparam logic [CNT_W-1:0] TDIV =
    CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] RST_PERIOD =
    CNT_W'(DEFAULT_TREFI * TICK_DIV - 1);
  localparam logic [CNT_W-1:0] EPOCH_LAST =
    CNT_W'(EPOCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(WALK_TIMEOUT - 1);
  localparam logic [7:0] DEF_T =
    8'(DEFAULT_TREFI);
  localparam logic [3:0] PMAX =
    4'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] epoch_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       staged;
  logic             tick;
  logic             ack_ok;
  logic             ovf_set;
  logic             tmo_set;
  logic             inv_set;
  logic             walk_ok;
`ifdef RF_SCHED_HYST_EN
  logic [7:0]       prev_pred;
`endif

  assign tick    = enable && (period_cnt == '0);
  assign ack_ok  = ref_ack && ref_req && (pending != '0);
  assign ovf_set = tick && !ack_ok && (pending == PMAX);
  assign walk_ok = (walk_t_refi == 8'd32) ||
                   (walk_t_refi == 8'd48) ||
                   (walk_t_refi == 8'd64);
  assign tmo_set = (state == REQ) && !walk_done &&
                   (tmo_cnt == TMO_LAST);
  assign inv_set = (state == REQ) && walk_done && !walk_ok;

  // New interval takes effect only on a reload, never mid-period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt <= RST_PERIOD;
      cur_t_refi <= DEF_T;
    end else if (tick) begin
      period_cnt <= CNT_W'(staged) * TDIV - CNT_W'(1);
      cur_t_refi <= staged;
    end else if (enable) begin
      period_cnt <= period_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending      <= '0;
      ref_req      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      ref_req      <= (pending != '0);
      err_overflow <= ovf_set | (err_overflow & ~clr_err);
      if (tick && !ack_ok) begin
        if (pending != PMAX)
          pending <= pending + 1'b1;
      end else if (!tick && ack_ok) begin
        pending <= pending - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      epoch_cnt   <= '0;
      tmo_cnt     <= '0;
      walk_start  <= 1'b0;
      staged      <= DEF_T;
      err_timeout <= 1'b0;
      err_invalid <= 1'b0;
`ifdef RF_SCHED_HYST_EN
      prev_pred   <= DEF_T;
      hyst_hold   <= 1'b0;
`endif
    end else begin
      err_timeout <= tmo_set | (err_timeout & ~clr_err);
      err_invalid <= inv_set | (err_invalid & ~clr_err);
`ifdef RF_SCHED_HYST_EN
      hyst_hold   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (enable) begin
            if (epoch_cnt == EPOCH_LAST) begin
              epoch_cnt  <= '0;
              tmo_cnt    <= '0;
              walk_start <= 1'b1;
              state      <= REQ;
            end else begin
              epoch_cnt <= epoch_cnt + 1'b1;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (walk_done) begin
            walk_start <= 1'b0;
            state      <= REL;
            if (walk_ok) begin
`ifdef RF_SCHED_HYST_EN
              if (walk_t_refi == prev_pred)
                staged <= walk_t_refi;
              else
                hyst_hold <= 1'b1;
              prev_pred <= walk_t_refi;
`else
              staged <= walk_t_refi;
`endif
            end
          end else if (tmo_cnt == TMO_LAST) begin
            walk_start <= 1'b0;
            state      <= REL;
          end
        end
        // Walker must see start low before the next epoch.
        REL: begin
          if (!walk_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
